vga_draw_arbiter: RTL and testbench
===================================

Name: vga_draw_arbiter

Overview:
Shares the single VGA plot port between the sprite-drawing FSMs: player ship, alien wave and bullets. Each requester asks for the port, receives an exclusive grant for a burst of pixels and streams (x, y, colour) pixels. The arbiter registers each pixel into the VGA adapter's x/y/colour/plot inputs. Requesters are served round-robin, so player redraws cannot be starved by alien sweeps.

Parameters:
NUM_REQ, 3, number of requesters (index 0 = player, 1 = aliens, 2 = bullets)
X_W, 8, pixel x-coordinate width
Y_W, 7, pixel y-coordinate width
COLOUR_W, 3, colour width
MAX_BURST, 16, maximum pixels accepted per grant before a forced release (>=1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester request, level, held until burst ends
pix_valid  in  NUM_REQ  per-requester pixel valid
pix_last  in  NUM_REQ  marks final pixel of a burst, qualified by pix_valid
pix_x  in  NUM_REQ*X_W  packed x coordinates, requester i at [i*X_W +: X_W]
pix_y  in  NUM_REQ*Y_W  packed y coordinates
pix_colour  in  NUM_REQ*COLOUR_W  packed colours
gnt  out  NUM_REQ  one-hot grant, registered
vga_x  out  X_W  to VGA adapter x
vga_y  out  Y_W  to VGA adapter y
vga_colour  out  COLOUR_W  to VGA adapter colour
vga_write_en  out  1  to VGA adapter plot strobe
busy  out  1  high while in BURST

Behaviour:
- Reset (asynchronous, reset_n low) sets the state to IDLE. All outputs go to 0: gnt=0, vga_x/y/colour=0, vga_write_en=0, busy=0. The round-robin pointer resets to NUM_REQ-1, so requester 0 has first priority.
- State IDLE: if any req bit is high, pick the winner by scanning from pointer+1 upward, mod NUM_REQ. On the next edge: gnt <= one-hot(winner), beat count <= 0, state <= BURST. If req is all zero, stay in IDLE with gnt=0.
- State BURST: busy=1. A pixel is accepted on an edge where the granted requester's pix_valid=1. pix_valid from non-granted requesters is ignored.
- Pixel path: on an accepted edge, vga_x/vga_y/vga_colour <= the granted slice and vga_write_en <= 1. Otherwise vga_write_en <= 0 and the coordinate/colour registers hold. Latency from accept to plot is 1 cycle.
- The beat counter increments per accepted pixel. Its width is clog2(MAX_BURST)+1.
- A burst ends on the edge where any of the following holds:
  (a) an accepted pixel has pix_last=1;
  (b) an accepted pixel is the MAX_BURST-th of the grant (forced release);
  (c) the granted requester drops req (abort; no pixel is accepted that cycle unless pix_valid=1, in which case that pixel is still plotted).
- At burst end: gnt <= 0, pointer <= winner index, state <= IDLE. gnt is therefore low for at least 1 cycle between consecutive bursts, even for the same requester.
- Requester rule: after a pix_last accept or a forced release, the requester must not assert pix_valid until it sees gnt again. A requester still holding req after a forced release re-enters arbitration behind the others.
- Simultaneous requests: resolved strictly round-robin relative to the last winner. No fixed priority exists after reset.
- If pix_last and the MAX_BURST limit coincide, treat it as a single release with no double-counting.
- Asserting reset mid-burst immediately drops gnt and vga_write_en. Any partial burst is discarded.
- A deasserting req while not granted has no effect.

Decomposition:
- Shared package holds: requester index constants (REQ_PLAYER=0, REQ_ALIEN=1, REQ_BULLET=2), the state encoding (IDLE, BURST), and the default coordinate and colour widths.
- Sub-module rr_picker: purely combinational. Takes req and pointer, outputs a one-hot winner and the winner index. Reused later for the bullet-slot allocator.

Test Plan:
- Reset, then no req for 10 cycles -> gnt=0, vga_write_en=0, busy=0 throughout.
- req=3'b001, requester 0 streams 6 pixels, (10,20,3'b111) through (15,20,3'b111), last on the 6th -> gnt=001 one cycle after req. Six vga_write_en pulses, each 1 cycle after its accept, with vga_x 10..15. gnt drops the cycle after the 6th accept.
- req=3'b111 held; each requester sends 2-pixel bursts -> grant order 001, 010, 100, 001, with exactly 1 idle gnt cycle between bursts.
- Requester 1 streams 20 pixels with no pix_last, MAX_BURST=16 -> 16 plots, then forced release. Requester 1 is regranted only after pending requester 2 is served.
- Requester 2 granted, then drops req after 3 pixels with no last -> 3 plots, gnt=0 next cycle, pointer=2, and requester 0 wins the next arbitration.
- reset_n pulsed low mid-burst after 4 pixels -> gnt and vga_write_en go 0 asynchronously. After release, requester 0 wins the first arbitration.

Source files
------------

// File: rtl/vga_draw_arbiter_pkg.sv
// Shared definitions for the VGA draw-port arbiter: requester indices,
// FSM state encoding and default bus widths.
package vga_draw_arbiter_pkg;

    localparam int NUM_REQ_DEF   = 3;
    localparam int X_W_DEF       = 8;
    localparam int Y_W_DEF       = 7;
    localparam int COLOUR_W_DEF  = 3;
    localparam int MAX_BURST_DEF = 16;

    // Requester slots on the shared plot port
    localparam int REQ_PLAYER = 0;
    localparam int REQ_ALIEN  = 1;
    localparam int REQ_BULLET = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    // Width of an index able to address n requesters (at least one bit)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_draw_arbiter_if.sv
// Requester/VGA-side bundle of the draw arbiter. The master side is the
// collection of sprite FSMs plus the VGA adapter; the arbiter is the slave.
interface vga_draw_arbiter_if
    import vga_draw_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int X_W      = X_W_DEF,
    parameter int Y_W      = Y_W_DEF,
    parameter int COLOUR_W = COLOUR_W_DEF
) ();

    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ-1:0]          pix_valid;
    logic [NUM_REQ-1:0]          pix_last;
    logic [NUM_REQ*X_W-1:0]      pix_x;
    logic [NUM_REQ*Y_W-1:0]      pix_y;
    logic [NUM_REQ*COLOUR_W-1:0] pix_colour;

    logic [NUM_REQ-1:0]          gnt;
    logic [X_W-1:0]              vga_x;
    logic [Y_W-1:0]              vga_y;
    logic [COLOUR_W-1:0]         vga_colour;
    logic                        vga_write_en;
    logic                        busy;

    modport master (
        output req, pix_valid, pix_last, pix_x, pix_y, pix_colour,
        input  gnt, vga_x, vga_y, vga_colour, vga_write_en, busy
    );

    modport slave (
        input  req, pix_valid, pix_last, pix_x, pix_y, pix_colour,
        output gnt, vga_x, vga_y, vga_colour, vga_write_en, busy
    );

endinterface

// File: rtl/vga_draw_arbiter_rr_picker.sv
// Combinational round-robin picker: scans req starting one above the
// pointer (wrapping) and returns the first requester found.
module vga_draw_arbiter_rr_picker
    import vga_draw_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] win_onehot_o,
    output logic [IDX_W-1:0]   win_idx_o,
    output logic               any_o
);

    logic [IDX_W-1:0] cand;

    // First active request after the pointer wins; the pointer itself is checked last
    always_comb begin
        win_onehot_o = '0;
        win_idx_o    = '0;
        any_o        = 1'b0;
        cand         = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
            if (!any_o && req_i[cand]) begin
                any_o              = 1'b1;
                win_onehot_o[cand] = 1'b1;
                win_idx_o          = cand;
            end
        end
    end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Shares the VGA plot port between sprite FSMs. A winner is picked
// round-robin in IDLE, then owns the port for one burst; every accepted
// pixel is registered onto the adapter inputs one cycle later.
//
// state    | meaning
// ST_IDLE  | no owner, gnt low; arbitrate whenever any req is high
// ST_BURST | one requester granted; pixels accepted on its pix_valid
module vga_draw_arbiter
    import vga_draw_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int X_W       = X_W_DEF,
    parameter int Y_W       = Y_W_DEF,
    parameter int COLOUR_W  = COLOUR_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input logic               clk,
    input logic               reset_n,
    vga_draw_arbiter_if.slave bus
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    arb_state_t          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    win_q, win_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic                we_q, we_d;

    logic [NUM_REQ-1:0]  pick_onehot;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;

    logic                sel_req, sel_valid, sel_last;
    logic [X_W-1:0]      sel_x;
    logic [Y_W-1:0]      sel_y;
    logic [COLOUR_W-1:0] sel_colour;

    logic                accept;
    logic                burst_end;
    logic [CNT_W-1:0]    beat_next;

    vga_draw_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i        (bus.req),
        .ptr_i        (ptr_q),
        .win_onehot_o (pick_onehot),
        .win_idx_o    (pick_idx),
        .any_o        (pick_any)
    );

    // Route the granted requester's handshake and pixel slice
    always_comb begin
        sel_req    = 1'b0;
        sel_valid  = 1'b0;
        sel_last   = 1'b0;
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_q == IDX_W'(i)) begin
                sel_req    = bus.req[i];
                sel_valid  = bus.pix_valid[i];
                sel_last   = bus.pix_last[i];
                sel_x      = bus.pix_x[i*X_W +: X_W];
                sel_y      = bus.pix_y[i*Y_W +: Y_W];
                sel_colour = bus.pix_colour[i*COLOUR_W +: COLOUR_W];
            end
        end
    end

    // Burst termination: last pixel, beat limit reached, or owner dropped req.
    // pix_last on the MAX_BURST-th beat is one release, not two.
    always_comb begin
        accept    = (state_q == ST_BURST) && sel_valid;
        beat_next = cnt_q + CNT_W'(1);
        burst_end = (state_q == ST_BURST) &&
                    ((accept && (sel_last || (beat_next == CNT_W'(MAX_BURST)))) || !sel_req);
    end

    // Next-state and next-output computation for the arbiter FSM
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        gnt_d    = gnt_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        we_d     = 1'b0;

        if (state_q == ST_IDLE) begin
            if (pick_any) begin
                state_d = ST_BURST;
                gnt_d   = pick_onehot;
                win_d   = pick_idx;
                cnt_d   = '0;
            end
        end else begin
            if (accept) begin
                x_d      = sel_x;
                y_d      = sel_y;
                colour_d = sel_colour;
                we_d     = 1'b1;
                cnt_d    = beat_next;
            end
            // Releasing to IDLE guarantees a gnt-low cycle between bursts
            if (burst_end) begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                ptr_d   = win_q;
            end
        end
    end

    // State and registered outputs; reset pointer makes requester 0 first
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= IDX_W'(NUM_REQ - 1);
            win_q    <= '0;
            gnt_q    <= '0;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            gnt_q    <= gnt_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            we_q     <= we_d;
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.vga_x        = x_q;
    assign bus.vga_y        = y_q;
    assign bus.vga_colour   = colour_q;
    assign bus.vga_write_en = we_q;
    assign bus.busy         = (state_q == ST_BURST);

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Self-checking bench for vga_draw_arbiter: directed vector table,
// hand-written corner sequences and a randomized run against a
// transaction-level reference model.
module tb_vga_draw_arbiter;
    import vga_draw_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;
    localparam int MB = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    vga_draw_arbiter_if #(.NUM_REQ(N), .X_W(XW), .Y_W(YW), .COLOUR_W(CW)) bus ();

    vga_draw_arbiter #(
        .NUM_REQ(N), .X_W(XW), .Y_W(YW), .COLOUR_W(CW), .MAX_BURST(MB)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit          rst;
        logic [2:0]  req, val, last;
        logic [7:0]  x;
        logic [2:0]  e_gnt;
        logic        e_we;
        logic [7:0]  e_x;
        logic [6:0]  e_y;
        logic [2:0]  e_c;
        logic        e_busy;
    } vec_t;

    vec_t tv[$];

    // reference model state for the randomized phase
    int         owner, lastw, beats;
    logic [2:0] e_gnt;
    logic       e_we, e_busy;
    logic [7:0] e_x;
    logic [6:0] e_y;
    logic [2:0] e_c;
    bit         r_act[N];
    int         r_left[N];
    bit         r_nolast[N];
    int         plots;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] outs();
        return {9'd0, bus.gnt, bus.vga_write_en, bus.vga_x, bus.vga_y, bus.vga_colour, bus.busy};
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_idle();
        bus.req        = '0;
        bus.pix_valid  = '0;
        bus.pix_last   = '0;
        bus.pix_x      = '0;
        bus.pix_y      = '0;
        bus.pix_colour = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic set_pix(input int r, input logic v, input logic l, input int x);
        bus.pix_valid[r]             = v;
        bus.pix_last[r]              = l;
        bus.pix_x[r*XW +: XW]        = XW'(x);
        bus.pix_y[r*YW +: YW]        = YW'(30 + r);
        bus.pix_colour[r*CW +: CW]   = CW'(r + 1);
    endtask

    task automatic add(input bit rst, input logic [2:0] req, input logic [2:0] val,
                       input logic [2:0] last, input logic [7:0] x,
                       input logic [2:0] g, input logic we, input logic [7:0] ex,
                       input logic [6:0] ey, input logic [2:0] ec, input logic b);
        vec_t v;
        v.rst = rst; v.req = req; v.val = val; v.last = last; v.x = x;
        v.e_gnt = g; v.e_we = we; v.e_x = ex; v.e_y = ey; v.e_c = ec; v.e_busy = b;
        tv.push_back(v);
    endtask

    // Reference: owner = -1 means the port is free; winner is the first
    // requester after the previous winner, counting modulo N.
    task automatic model_step();
        bit acc, done, found;
        if (owner < 0) begin
            e_we = 1'b0;
            if (bus.req != 0) begin
                found = 0;
                for (int k = 1; k <= N; k++) begin
                    if (!found && bus.req[(lastw + k) % N]) begin
                        owner = (lastw + k) % N;
                        found = 1;
                    end
                end
                beats  = 0;
                e_gnt  = 3'(1 << owner);
                e_busy = 1'b1;
            end
        end else begin
            acc  = bus.pix_valid[owner];
            e_we = acc;
            if (acc) begin
                e_x = bus.pix_x[owner*XW +: XW];
                e_y = bus.pix_y[owner*YW +: YW];
                e_c = bus.pix_colour[owner*CW +: CW];
                beats++;
                r_left[owner]--;
                if (bus.pix_last[owner]) r_act[owner] = 0;
            end
            done = (acc && (bus.pix_last[owner] || beats == MB)) || !bus.req[owner];
            if (done) begin
                lastw  = owner;
                owner  = -1;
                e_gnt  = '0;
                e_busy = 1'b0;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();

        // ---------------- directed vector table ----------------
        add(1, 3'b000, 3'b000, 3'b000, 8'd0,  3'b000, 0, 8'd0, 7'd0, 3'd0, 0);
        for (int k = 0; k < 10; k++)
            add(0, 3'b000, 3'b000, 3'b000, 8'd0, 3'b000, 0, 8'd0, 7'd0, 3'd0, 0);
        add(0, 3'b001, 3'b000, 3'b000, 8'd0,  3'b001, 0, 8'd0, 7'd0, 3'd0, 1);
        for (int k = 0; k < 6; k++)
            add(0, 3'b001, 3'b001, (k == 5) ? 3'b001 : 3'b000, 8'(10 + k),
                (k == 5) ? 3'b000 : 3'b001, 1, 8'(10 + k), 7'd20, 3'd7, (k == 5) ? 1'b0 : 1'b1);
        add(0, 3'b000, 3'b000, 3'b000, 8'd0,  3'b000, 0, 8'd15,  7'd20, 3'd7, 0);
        add(1, 3'b000, 3'b000, 3'b000, 8'd0,  3'b000, 0, 8'd0,   7'd0,  3'd0, 0);
        add(0, 3'b111, 3'b000, 3'b000, 8'd0,  3'b001, 0, 8'd0,   7'd0,  3'd0, 1);
        add(0, 3'b111, 3'b001, 3'b000, 8'd30, 3'b001, 1, 8'd30,  7'd20, 3'd7, 1);
        add(0, 3'b111, 3'b001, 3'b001, 8'd31, 3'b000, 1, 8'd31,  7'd20, 3'd7, 0);
        add(0, 3'b111, 3'b000, 3'b000, 8'd0,  3'b010, 0, 8'd31,  7'd20, 3'd7, 1);
        add(0, 3'b111, 3'b010, 3'b000, 8'd40, 3'b010, 1, 8'd120, 7'd21, 3'd6, 1);
        add(0, 3'b111, 3'b010, 3'b010, 8'd41, 3'b000, 1, 8'd121, 7'd21, 3'd6, 0);
        add(0, 3'b111, 3'b000, 3'b000, 8'd0,  3'b100, 0, 8'd121, 7'd21, 3'd6, 1);
        add(0, 3'b111, 3'b100, 3'b000, 8'd50, 3'b100, 1, 8'd210, 7'd22, 3'd5, 1);
        add(0, 3'b111, 3'b100, 3'b100, 8'd51, 3'b000, 1, 8'd211, 7'd22, 3'd5, 0);
        add(0, 3'b111, 3'b000, 3'b000, 8'd0,  3'b001, 0, 8'd211, 7'd22, 3'd5, 1);
        add(0, 3'b111, 3'b011, 3'b010, 8'd5,  3'b001, 1, 8'd5,   7'd20, 3'd7, 1);
        add(0, 3'b111, 3'b001, 3'b001, 8'd6,  3'b000, 1, 8'd6,   7'd20, 3'd7, 0);

        for (int i = 0; i < tv.size(); i++) begin
            reset_n       = !tv[i].rst;
            bus.req       = tv[i].req;
            bus.pix_valid = tv[i].val;
            bus.pix_last  = tv[i].last;
            for (int r = 0; r < N; r++) begin
                bus.pix_x[r*XW +: XW]      = tv[i].x + 8'(r * 80);
                bus.pix_y[r*YW +: YW]      = 7'(20 + r);
                bus.pix_colour[r*CW +: CW] = 3'(7 - r);
            end
            cyc();
            chk($sformatf("vec%0d", i), outs(),
                {9'd0, tv[i].e_gnt, tv[i].e_we, tv[i].e_x, tv[i].e_y, tv[i].e_c, tv[i].e_busy});
            reset_n = 1'b1;
        end

        // ---------------- forced release at MAX_BURST ----------------
        do_reset();
        bus.req = 3'b010;
        cyc();
        chk("fr_grant", bus.gnt, 3'b010);
        plots = 0;
        for (int k = 0; k < 16; k++) begin
            set_pix(REQ_ALIEN, 1, 0, k);
            if (k == 2) bus.req[REQ_BULLET] = 1'b1;
            cyc();
            plots += int'(bus.vga_write_en);
            chk("fr_x", bus.vga_x, k);
            chk("fr_gnt", bus.gnt, (k == 15) ? 32'd0 : 32'd2);
        end
        set_pix(REQ_ALIEN, 0, 0, 0);
        cyc();
        chk("fr_plots", plots, 16);
        chk("fr_next_gnt", bus.gnt, 3'b100);
        set_pix(REQ_BULLET, 1, 1, 99);
        cyc();
        chk("fr_bullet_plot", {bus.vga_write_en, bus.vga_x, bus.gnt}, {1'b1, 8'd99, 3'b000});
        set_pix(REQ_BULLET, 0, 0, 0);
        bus.req[REQ_BULLET] = 1'b0;
        cyc();
        chk("fr_regrant", bus.gnt, 3'b010);
        for (int k = 16; k < 20; k++) begin
            set_pix(REQ_ALIEN, 1, k == 19, k);
            cyc();
            chk("fr_tail", {bus.vga_write_en, bus.vga_x}, {1'b1, 8'(k)});
        end
        chk("fr_tail_end", bus.gnt, 3'b000);

        // ---------------- abort by dropping req ----------------
        do_reset();
        bus.req = 3'b100;
        cyc();
        chk("ab_grant", bus.gnt, 3'b100);
        for (int k = 0; k < 3; k++) begin
            set_pix(REQ_BULLET, 1, 0, 40 + k);
            cyc();
            chk("ab_plot", {bus.vga_write_en, bus.vga_x}, {1'b1, 8'(40 + k)});
        end
        set_pix(REQ_BULLET, 0, 0, 0);
        bus.req = 3'b011;
        cyc();
        chk("ab_release", {bus.gnt, bus.vga_write_en, bus.busy}, {3'b000, 1'b0, 1'b0});
        cyc();
        chk("ab_next_player", bus.gnt, 3'b001);

        // ---------------- reset mid-burst ----------------
        do_reset();
        bus.req = 3'b010;
        cyc();
        for (int k = 0; k < 4; k++) begin
            set_pix(REQ_ALIEN, 1, 0, 60 + k);
            cyc();
        end
        chk("rs_pre", {bus.gnt, bus.vga_write_en}, {3'b010, 1'b1});
        #2 reset_n = 1'b0;
        #1;
        chk("rs_async", {bus.gnt, bus.vga_write_en, bus.busy, bus.vga_x},
            {3'b000, 1'b0, 1'b0, 8'd0});
        set_pix(REQ_ALIEN, 0, 0, 0);
        bus.req = 3'b011;
        @(negedge clk);
        reset_n = 1'b1;
        cyc();
        chk("rs_first_win", bus.gnt, 3'b001);

        // ---------------- randomized run vs reference model ----------------
        do_reset();
        owner = -1; lastw = N - 1; beats = 0;
        e_gnt = '0; e_we = 0; e_busy = 0; e_x = '0; e_y = '0; e_c = '0;
        for (int i = 0; i < N; i++) begin
            r_act[i] = 0; r_left[i] = 0; r_nolast[i] = 0;
        end
        for (int cnum = 0; cnum < 3000; cnum++) begin
            for (int i = 0; i < N; i++) begin
                if (!r_act[i] && $urandom_range(0, 3) == 0) begin
                    r_act[i]    = 1;
                    r_left[i]   = $urandom_range(1, 24);
                    r_nolast[i] = ($urandom_range(0, 3) == 0);
                end
                bus.req[i]                 = r_act[i];
                bus.pix_valid[i]           = 1'b0;
                bus.pix_last[i]            = 1'b0;
                bus.pix_x[i*XW +: XW]      = XW'($urandom);
                bus.pix_y[i*YW +: YW]      = YW'($urandom);
                bus.pix_colour[i*CW +: CW] = CW'($urandom);
                if (e_gnt[i]) begin
                    if ($urandom_range(0, 24) == 0 || (r_nolast[i] && r_left[i] <= 0)) begin
                        bus.req[i] = 1'b0;
                        r_act[i]   = 0;
                    end
                    bus.pix_valid[i] = ($urandom_range(0, 3) != 0);
                    bus.pix_last[i]  = bus.pix_valid[i] && !r_nolast[i] && (r_left[i] == 1);
                end else if (!r_act[i]) begin
                    bus.pix_valid[i] = 1'($urandom_range(0, 1));
                    bus.pix_last[i]  = 1'($urandom_range(0, 1));
                end
            end
            @(posedge clk);
            model_step();
            @(negedge clk);
            chk($sformatf("rand%0d", cnum), outs(),
                {9'd0, e_gnt, e_we, e_x, e_y, e_c, e_busy});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
